address_ram_map: RTL and testbench
==================================

Name: address_ram_map

Overview:
- Registered address-map lookup for the neural-net loader.
- Given the current sequencer step, returns the first and last word address of that step's data segment in the shared 8K-word input RAM, plus a RAM read enable.
- Consumed by the memory-transfer block, which walks addresses firstaddr..lastaddr inclusive into pixel or weight memories.
- RAM layout: picture first, then six convolution-weight blocks, then the dense-layer weight block, packed contiguously.

Parameters:
- picture_size, 28, picture edge length in pixels; picture segment = picture_size*picture_size words.
- convolution_size, 9, words per convolution kernel.
- KERN_1, 4, kernel count of conv layer 1 (step 2).
- KERN_2, 16, kernel count of conv layer 2 (step 4).
- KERN_3, 16, kernel count of conv layer 3 (step 6).
- KERN_4, 32, kernel count of conv layer 4 (step 8).
- KERN_5, 32, kernel count of conv layer 5 (step 10).
- KERN_6, 64, kernel count of conv layer 6 (step 12).
- DENSE_LEN, 640, word count of the dense weight segment (step 14).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- step  input  5  current sequencer step.
- re_RAM  output  1  1 = current step reads the input RAM.
- firstaddr  output  13  first word address of the segment.
- lastaddr  output  13  last word address of the segment, inclusive.

Behaviour:
- Reset: one clock, reset synchronous and active-high (clk, rst). While rst=1 at a clock edge, outputs go to re_RAM=0, firstaddr=0, lastaddr=0.
- Latency: outputs are registered, 1 clock after step is sampled. A step change at edge N appears at edge N+1. A constant step holds the outputs constant.
- Segment lengths:
  - LEN1 = picture_size^2.
  - LEN2 = KERN_1*convolution_size.
  - LEN4 = KERN_2*convolution_size, and so on through LEN12 = KERN_6*convolution_size.
  - LEN14 = DENSE_LEN.
- Bases are cumulative, computed at elaboration:
  - BASE1 = 0.
  - BASE2 = LEN1.
  - BASE4 = BASE2+LEN2, and so on through BASE14 = BASE12+LEN12.
- Active steps 1,2,4,6,8,10,12,14: re_RAM=1, firstaddr=BASEs, lastaddr=BASEs+LENs-1.
- All other step values (0, odd 3..13, 15..31): re_RAM=0, firstaddr=0, lastaddr=0.
- Default values:
  - step 1: 0..783.
  - step 2: 784..819.
  - step 4: 820..963.
  - step 6: 964..1107.
  - step 8: 1108..1395.
  - step 10: 1396..1683.
  - step 12: 1684..2259.
  - step 14: 2260..2899.
- Arithmetic: base/last sums are computed at elaboration in 32 bits, then truncated to 13 bits (addresses wrap mod 8192).
- Zero-length segment: firstaddr=lastaddr=BASE, re_RAM=1.
- Reset during an active step overrides the lookup. The first edge after rst falls outputs the entry for the current step.
- Step may jump non-sequentially; the output simply follows the table 1 clock later.

Optional Feature:
- Macro ADDRRAM_OVF_CHECK_EN.
- When defined:
  - adds output port ovf (1 bit, registered, same latency, reset 0);
  - ovf=1 when the selected active step's untruncated BASE+LEN-1 > 8191, else 0;
  - ovf is 0 for inactive steps.
- When not defined: no ovf port; wrap mod 8192 silently.

Test Plan:
- Reset: rst=1 for 2 clocks with step=1 -> re_RAM=0, firstaddr=0, lastaddr=0. Release -> next clock re_RAM=1, 0/783.
- Sweep step 0..31, one per clock, default parameters -> each output one clock later matches the table, e.g. step 12 -> 1684/2259, step 3 -> re_RAM=0, 0/0.
- Hold step=14 for 10 clocks -> outputs constant at 2260/2899, re_RAM=1.
- Non-sequential: step 2 -> 14 -> 1 on consecutive clocks -> 784/819, then 2260/2899, then 0/783.
- Override picture_size=8, KERN_1=1 -> step 1 gives 0..63, step 2 gives 64..72.
- With ADDRRAM_OVF_CHECK_EN and DENSE_LEN=6000 -> step 14 gives ovf=1, firstaddr=2260, lastaddr=(8259 mod 8192)=67; step 12 gives ovf=0.

Source files
------------

// File: rtl/address_ram_map.sv
// address_ram_map: registered lookup of the input-RAM segment for the
// current sequencer step. The RAM holds the picture, six conv weight blocks
// and the dense weight block, packed back to back. Outputs follow step one
// clock later.
// Optional: define ADDRRAM_OVF_CHECK_EN to add the registered ovf output.
// It flags a segment whose end runs past the 8K-word RAM.
module address_ram_map #(
    parameter int picture_size     = 28,
    parameter int convolution_size = 9,
    parameter int KERN_1           = 4,
    parameter int KERN_2           = 16,
    parameter int KERN_3           = 16,
    parameter int KERN_4           = 32,
    parameter int KERN_5           = 32,
    parameter int KERN_6           = 64,
    parameter int DENSE_LEN        = 640
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  step,
    output logic        re_RAM,
    output logic [12:0] firstaddr,
`ifdef ADDRRAM_OVF_CHECK_EN
    output logic [12:0] lastaddr,
    output logic        ovf
`else
    output logic [12:0] lastaddr
`endif
);

    // Segment lengths in RAM order.
    localparam int LEN1  = picture_size * picture_size;
    localparam int LEN2  = KERN_1 * convolution_size;
    localparam int LEN4  = KERN_2 * convolution_size;
    localparam int LEN6  = KERN_3 * convolution_size;
    localparam int LEN8  = KERN_4 * convolution_size;
    localparam int LEN10 = KERN_5 * convolution_size;
    localparam int LEN12 = KERN_6 * convolution_size;
    localparam int LEN14 = DENSE_LEN;

    // Cumulative bases, full 32-bit before truncation.
    localparam int BASE1  = 0;
    localparam int BASE2  = BASE1  + LEN1;
    localparam int BASE4  = BASE2  + LEN2;
    localparam int BASE6  = BASE4  + LEN4;
    localparam int BASE8  = BASE6  + LEN6;
    localparam int BASE10 = BASE8  + LEN8;
    localparam int BASE12 = BASE10 + LEN10;
    localparam int BASE14 = BASE12 + LEN12;

    // A zero-length segment reports its base as both first and last.
    localparam int LAST1  = (LEN1  == 0) ? BASE1  : BASE1  + LEN1  - 1;
    localparam int LAST2  = (LEN2  == 0) ? BASE2  : BASE2  + LEN2  - 1;
    localparam int LAST4  = (LEN4  == 0) ? BASE4  : BASE4  + LEN4  - 1;
    localparam int LAST6  = (LEN6  == 0) ? BASE6  : BASE6  + LEN6  - 1;
    localparam int LAST8  = (LEN8  == 0) ? BASE8  : BASE8  + LEN8  - 1;
    localparam int LAST10 = (LEN10 == 0) ? BASE10 : BASE10 + LEN10 - 1;
    localparam int LAST12 = (LEN12 == 0) ? BASE12 : BASE12 + LEN12 - 1;
    localparam int LAST14 = (LEN14 == 0) ? BASE14 : BASE14 + LEN14 - 1;

    // Tables indexed by slot 0..7 (steps 1,2,4,...,14), addresses wrap mod 8192.
    localparam logic [7:0][12:0] FIRST_TAB = {
        13'(BASE14), 13'(BASE12), 13'(BASE10), 13'(BASE8),
        13'(BASE6),  13'(BASE4),  13'(BASE2),  13'(BASE1)
    };
    localparam logic [7:0][12:0] LAST_TAB = {
        13'(LAST14), 13'(LAST12), 13'(LAST10), 13'(LAST8),
        13'(LAST6),  13'(LAST4),  13'(LAST2),  13'(LAST1)
    };

`ifdef ADDRRAM_OVF_CHECK_EN
    // BASE+LEN-1 > 8191 written as BASE+LEN > 8192 so LEN=0 cannot underflow.
    localparam logic [7:0] OVF_TAB = {
        (BASE14 + LEN14 > 8192), (BASE12 + LEN12 > 8192),
        (BASE10 + LEN10 > 8192), (BASE8  + LEN8  > 8192),
        (BASE6  + LEN6  > 8192), (BASE4  + LEN4  > 8192),
        (BASE2  + LEN2  > 8192), (BASE1  + LEN1  > 8192)
    };
    logic        ovf_n;
`endif

    logic        hit;
    logic [2:0]  slot;
    logic        re_n;
    logic [12:0] first_n;
    logic [12:0] last_n;

    // Decode the step into a table slot and form the next output values.
    always_comb begin
        hit     = 1'b0;
        slot    = '0;
        re_n    = 1'b0;
        first_n = '0;
        last_n  = '0;
`ifdef ADDRRAM_OVF_CHECK_EN
        ovf_n   = 1'b0;
`endif
        case (step)
            5'd1:    begin hit = 1'b1; slot = 3'd0; end
            5'd2:    begin hit = 1'b1; slot = 3'd1; end
            5'd4:    begin hit = 1'b1; slot = 3'd2; end
            5'd6:    begin hit = 1'b1; slot = 3'd3; end
            5'd8:    begin hit = 1'b1; slot = 3'd4; end
            5'd10:   begin hit = 1'b1; slot = 3'd5; end
            5'd12:   begin hit = 1'b1; slot = 3'd6; end
            5'd14:   begin hit = 1'b1; slot = 3'd7; end
            default: begin hit = 1'b0; slot = 3'd0; end
        endcase
        if (hit) begin
            re_n    = 1'b1;
            first_n = FIRST_TAB[slot];
            last_n  = LAST_TAB[slot];
`ifdef ADDRRAM_OVF_CHECK_EN
            ovf_n   = OVF_TAB[slot];
`endif
        end
    end

    // Output register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            re_RAM    <= 1'b0;
            firstaddr <= '0;
            lastaddr  <= '0;
`ifdef ADDRRAM_OVF_CHECK_EN
            ovf       <= 1'b0;
`endif
        end else begin
            re_RAM    <= re_n;
            firstaddr <= first_n;
            lastaddr  <= last_n;
`ifdef ADDRRAM_OVF_CHECK_EN
            ovf       <= ovf_n;
`endif
        end
    end

endmodule

// File: tb/tb_address_ram_map.sv
// Bench for address_ram_map: default instance, a small-picture override
// instance and, with ADDRRAM_OVF_CHECK_EN, an oversize dense-layer instance,
// all compared each cycle against a segment-list reference model.
module tb_address_ram_map;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  step = 5'd1;

    logic        re_d, re_o;
    logic [12:0] fa_d, la_d, fa_o, la_o;
`ifdef ADDRRAM_OVF_CHECK_EN
    logic        ov_d, ov_o, re_v, ov_v;
    logic [12:0] fa_v, la_v;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    address_ram_map dut (
        .clk(clk), .rst(rst), .step(step),
        .re_RAM(re_d), .firstaddr(fa_d),
`ifdef ADDRRAM_OVF_CHECK_EN
        .lastaddr(la_d), .ovf(ov_d)
`else
        .lastaddr(la_d)
`endif
    );

    address_ram_map #(.picture_size(8), .KERN_1(1)) dut_ovr (
        .clk(clk), .rst(rst), .step(step),
        .re_RAM(re_o), .firstaddr(fa_o),
`ifdef ADDRRAM_OVF_CHECK_EN
        .lastaddr(la_o), .ovf(ov_o)
`else
        .lastaddr(la_o)
`endif
    );

`ifdef ADDRRAM_OVF_CHECK_EN
    address_ram_map #(.DENSE_LEN(6000)) dut_ovf (
        .clk(clk), .rst(rst), .step(step),
        .re_RAM(re_v), .firstaddr(fa_v), .lastaddr(la_v), .ovf(ov_v)
    );
`endif

    // Reference: walk the segment list in RAM order accumulating bases.
    function automatic void model(input int ps, input int k1, input int dl,
                                  input bit r, input int s,
                                  output bit re, output int fa, output int la,
                                  output bit ov);
        int order[8];
        int lens[8];
        int base;
        order = '{1, 2, 4, 6, 8, 10, 12, 14};
        lens  = '{ps * ps, k1 * 9, 16 * 9, 16 * 9, 32 * 9, 32 * 9, 64 * 9, dl};
        base = 0;
        re = 1'b0; fa = 0; la = 0; ov = 1'b0;
        if (!r) begin
            for (int i = 0; i < 8; i++) begin
                if (order[i] == s) begin
                    re = 1'b1;
                    fa = base % 8192;
                    la = ((lens[i] == 0) ? base : base + lens[i] - 1) % 8192;
                    ov = (base + lens[i] - 1) > 8191;
                end
                base += lens[i];
            end
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (step=%0d rst=%0b t=%0t)",
                     name, act, exp, step, rst, $time);
        end
    endtask

    // Drive one step value, let it be sampled, then compare every instance.
    task automatic tick(input bit r, input int s);
        bit e_re, e_ov;
        int e_fa, e_la;
        rst  = r;
        step = 5'(s);
        @(posedge clk);
        #1;
        model(28, 4, 640, r, s, e_re, e_fa, e_la, e_ov);
        check("def.re_RAM", int'(re_d), int'(e_re));
        check("def.firstaddr", int'(fa_d), e_fa);
        check("def.lastaddr", int'(la_d), e_la);
`ifdef ADDRRAM_OVF_CHECK_EN
        check("def.ovf", int'(ov_d), int'(e_ov));
`endif
        model(8, 1, 640, r, s, e_re, e_fa, e_la, e_ov);
        check("ovr.re_RAM", int'(re_o), int'(e_re));
        check("ovr.firstaddr", int'(fa_o), e_fa);
        check("ovr.lastaddr", int'(la_o), e_la);
`ifdef ADDRRAM_OVF_CHECK_EN
        check("ovr.ovf", int'(ov_o), int'(e_ov));
        model(28, 4, 6000, r, s, e_re, e_fa, e_la, e_ov);
        check("big.re_RAM", int'(re_v), int'(e_re));
        check("big.firstaddr", int'(fa_v), e_fa);
        check("big.lastaddr", int'(la_v), e_la);
        check("big.ovf", int'(ov_v), int'(e_ov));
`endif
    endtask

    initial begin
        // Reset held two clocks with an active step.
        tick(1, 1);
        tick(1, 1);
        check("reset.re_RAM", int'(re_d), 0);
        check("reset.lastaddr", int'(la_d), 0);
        tick(0, 1);
        check("rel.re_RAM", int'(re_d), 1);
        check("rel.lastaddr", int'(la_d), 783);
        check("ovr1.lastaddr", int'(la_o), 63);

        // Full sweep of the step range.
        for (int s = 0; s < 32; s++) begin
            tick(0, s);
            if (s == 12) begin
                check("s12.firstaddr", int'(fa_d), 1684);
                check("s12.lastaddr", int'(la_d), 2259);
            end
            if (s == 3) check("s3.re_RAM", int'(re_d), 0);
            if (s == 2) begin
                check("ovr2.firstaddr", int'(fa_o), 64);
                check("ovr2.lastaddr", int'(la_o), 72);
            end
        end

        // Hold step 14.
        for (int i = 0; i < 10; i++) begin
            tick(0, 14);
            check("hold.firstaddr", int'(fa_d), 2260);
            check("hold.lastaddr", int'(la_d), 2899);
        end

        // Non-sequential jumps.
        tick(0, 2);
        check("jmp2.firstaddr", int'(fa_d), 784);
        check("jmp2.lastaddr", int'(la_d), 819);
        tick(0, 14);
        check("jmp14.firstaddr", int'(fa_d), 2260);
        tick(0, 1);
        check("jmp1.firstaddr", int'(fa_d), 0);
        check("jmp1.lastaddr", int'(la_d), 783);

`ifdef ADDRRAM_OVF_CHECK_EN
        tick(0, 14);
        check("big14.ovf", int'(ov_v), 1);
        check("big14.firstaddr", int'(fa_v), 2260);
        check("big14.lastaddr", int'(la_v), 67);
        tick(0, 12);
        check("big12.ovf", int'(ov_v), 0);
`endif

        // Reset asserted during an active step, then released.
        tick(0, 8);
        tick(1, 8);
        check("midrst.re_RAM", int'(re_d), 0);
        tick(0, 8);
        check("post.firstaddr", int'(fa_d), 1108);
        check("post.lastaddr", int'(la_d), 1395);

        // Random steps with occasional reset.
        for (int i = 0; i < 300; i++) begin
            tick(($urandom_range(0, 15) == 0), int'($urandom_range(0, 31)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
